// File: rtl/lane_deskew.sv
// Two-lane receive deskew buffer: per-lane byte FIFOs absorb up to DEPTH-1 cycles
// of inter-lane skew and release byte pairs launched together, with one common valid.
module lane_deskew #(
  parameter int DEPTH = 4
) (
  input  logic       clock4,
  input  logic       reset_L,
  input  logic [7:0] data_in0,
  input  logic       valid_in0,
  input  logic [7:0] data_in1,
  input  logic       valid_in1,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic       valid_out,
  output logic       aligned,
  output logic       skew_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] SKEW_MAX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKEW    = 2'd1,
    ALIGNED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem0_q [DEPTH];
  logic [7:0]      mem1_q [DEPTH];
  logic [AW-1:0]   wp0_q, wp0_d, rp0_q, rp0_d;
  logic [AW-1:0]   wp1_q, wp1_d, rp1_q, rp1_d;
  logic [CW-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [AW-1:0]   skew_cnt_q, skew_cnt_d;
  logic [7:0]      data_out0_q, data_out0_d, data_out1_q, data_out1_d;
  logic            valid_out_q, valid_out_d;
  logic            aligned_q, aligned_d;
  logic            skew_err_q, skew_err_d;

  logic pop, ovf, skew_to, err, wr0, wr1, empty_lane_wr;

  // Pops only when both lanes hold a byte at the start of the cycle.
  assign pop           = (cnt0_q != '0) && (cnt1_q != '0);
  assign ovf           = (valid_in0 && (cnt0_q == FULL_CNT) && !pop) ||
                         (valid_in1 && (cnt1_q == FULL_CNT) && !pop);
  assign empty_lane_wr = (cnt0_q == '0) ? valid_in0 : valid_in1;
  assign skew_to       = (state_q == SKEW) && (skew_cnt_q == SKEW_MAX) && !empty_lane_wr;
  assign err           = ovf || skew_to;
  assign wr0           = valid_in0 && !err;
  assign wr1           = valid_in1 && !err;

  always_comb begin
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    wp0_d       = wp0_q;
    wp1_d       = wp1_q;
    rp0_d       = rp0_q;
    rp1_d       = rp1_q;
    valid_out_d = 1'b0;
    data_out0_d = 8'h00;
    data_out1_d = 8'h00;
    skew_err_d  = skew_err_q || err;
    if (err) begin
      cnt0_d = '0;
      cnt1_d = '0;
      wp0_d  = '0;
      wp1_d  = '0;
      rp0_d  = '0;
      rp1_d  = '0;
    end else begin
      if (wr0) wp0_d = wp0_q + AW'(1);
      if (wr1) wp1_d = wp1_q + AW'(1);
      if (pop) begin
        rp0_d       = rp0_q + AW'(1);
        rp1_d       = rp1_q + AW'(1);
        valid_out_d = 1'b1;
        data_out0_d = mem0_q[rp0_q];
        data_out1_d = mem1_q[rp1_q];
      end
      if (wr0 && !pop)      cnt0_d = cnt0_q + CW'(1);
      else if (!wr0 && pop) cnt0_d = cnt0_q - CW'(1);
      if (wr1 && !pop)      cnt1_d = cnt1_q + CW'(1);
      else if (!wr1 && pop) cnt1_d = cnt1_q - CW'(1);
    end
  end

  // FSM next state follows the post-edge counts; skew_cnt runs only while the same lane stays empty.
  always_comb begin
    state_d    = IDLE;
    skew_cnt_d = '0;
    if ((cnt0_d != '0) && (cnt1_d != '0))      state_d = ALIGNED;
    else if ((cnt0_d != '0) || (cnt1_d != '0)) state_d = SKEW;
    if (!err && (state_q == SKEW) && (state_d == SKEW) &&
        ((cnt0_q == '0) == (cnt0_d == '0)))
      skew_cnt_d = skew_cnt_q + AW'(1);
    aligned_d = (state_d == ALIGNED);
  end

  always_ff @(posedge clock4 or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      skew_cnt_q  <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      wp0_q       <= '0;
      wp1_q       <= '0;
      rp0_q       <= '0;
      rp1_q       <= '0;
      data_out0_q <= 8'h00;
      data_out1_q <= 8'h00;
      valid_out_q <= 1'b0;
      aligned_q   <= 1'b0;
      skew_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      skew_cnt_q  <= skew_cnt_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
      wp0_q       <= wp0_d;
      wp1_q       <= wp1_d;
      rp0_q       <= rp0_d;
      rp1_q       <= rp1_d;
      data_out0_q <= data_out0_d;
      data_out1_q <= data_out1_d;
      valid_out_q <= valid_out_d;
      aligned_q   <= aligned_d;
      skew_err_q  <= skew_err_d;
    end
  end

  // Storage needs no reset: the counts decide what is live.
  always_ff @(posedge clock4) begin
    if (wr0) mem0_q[wp0_q] <= data_in0;
    if (wr1) mem1_q[wp1_q] <= data_in1;
  end

  assign data_out0 = data_out0_q;
  assign data_out1 = data_out1_q;
  assign valid_out = valid_out_q;
  assign aligned   = aligned_q;
  assign skew_err  = skew_err_q;

endmodule

// File: tb/tb_lane_deskew.sv
// Directed bench for lane_deskew (DEPTH=4): skew cases, errors, dropout and reset.
`timescale 1ns/1ps
module tb_lane_deskew;

  logic       clock4 = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] data_in0 = 8'h00, data_in1 = 8'h00;
  logic       valid_in0 = 1'b0, valid_in1 = 1'b0;
  logic [7:0] data_out0, data_out1;
  logic       valid_out, aligned, skew_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] pairs [$];
  logic [15:0] exp_q [$];

  lane_deskew #(.DEPTH(4)) dut (
    .clock4(clock4), .reset_L(reset_L),
    .data_in0(data_in0), .valid_in0(valid_in0),
    .data_in1(data_in1), .valid_in1(valid_in1),
    .data_out0(data_out0), .data_out1(data_out1),
    .valid_out(valid_out), .aligned(aligned), .skew_err(skew_err)
  );

  always #5 clock4 = ~clock4;

  always @(negedge clock4)
    if (valid_out) pairs.push_back({data_out0, data_out1});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    valid_in0 = v0; data_in0 = d0;
    valid_in1 = v1; data_in1 = d1;
    @(posedge clock4); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_npairs"}, 32'(pairs.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < pairs.size()) chk($sformatf("%s_pair%0d", tag, i), 32'(pairs[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #12;
    chk("rst_vld",  32'(valid_out), 0);
    chk("rst_dout", 32'({data_out0, data_out1}), 0);
    chk("rst_aln",  32'(aligned), 0);
    chk("rst_err",  32'(skew_err), 0);
    @(negedge clock4); reset_L = 1'b1;
    @(posedge clock4); #1;

    // Zero skew: pair appears one edge after the write.
    pairs.delete();
    cyc(1, 8'h11, 1, 8'hA1);
    chk("z0_vld", 32'(valid_out), 0);
    chk("z0_aln", 32'(aligned), 1);
    cyc(1, 8'h12, 1, 8'hA2);
    chk("z1_vld", 32'(valid_out), 1);
    chk("z1_dout", 32'({data_out0, data_out1}), 32'h11A1);
    cyc(1, 8'h13, 1, 8'hA3);
    cyc(1, 8'h14, 1, 8'hA4);
    cyc(0, 8'h00, 0, 8'h00);
    chk("z4_dout", 32'({data_out0, data_out1}), 32'h14A4);
    chk("z4_aln", 32'(aligned), 0);
    cyc(0, 8'h00, 0, 8'h00);
    chk("z5_vld", 32'(valid_out), 0);
    exp_q = '{16'h11A1, 16'h12A2, 16'h13A3, 16'h14A4};
    check_stream("zero");
    chk("zero_err", 32'(skew_err), 0);

    // Skew 3: lane 1 delayed three cycles.
    pairs.delete();
    cyc(1, 8'h11, 0, 8'h00);
    chk("s3_aln0", 32'(aligned), 0);
    cyc(1, 8'h12, 0, 8'h00);
    cyc(1, 8'h13, 0, 8'h00);
    cyc(1, 8'h14, 1, 8'hA1);
    chk("s3_vld3", 32'(valid_out), 0);
    chk("s3_aln3", 32'(aligned), 1);
    cyc(0, 8'h00, 1, 8'hA2);
    chk("s3_dout4", 32'({data_out0, data_out1}), 32'h11A1);
    cyc(0, 8'h00, 1, 8'hA3);
    cyc(0, 8'h00, 1, 8'hA4);
    idle(2);
    chk("s3_aln_end", 32'(aligned), 0);
    check_stream("skew3");
    chk("skew3_err", 32'(skew_err), 0);

    // Single-lane dropout: lane 1 pauses two cycles.
    pairs.delete();
    cyc(1, 8'h31, 1, 8'h41);
    cyc(1, 8'h32, 1, 8'h42);
    cyc(1, 8'h33, 0, 8'h00);
    cyc(1, 8'h34, 0, 8'h00);
    chk("dr_stall", 32'(valid_out), 0);
    cyc(1, 8'h35, 1, 8'h43);
    chk("dr_stall2", 32'(valid_out), 0);
    cyc(1, 8'h36, 1, 8'h44);
    chk("dr_resume", 32'({valid_out, data_out0, data_out1}), 32'h13343);
    cyc(0, 8'h00, 1, 8'h45);
    cyc(0, 8'h00, 1, 8'h46);
    idle(2);
    exp_q = '{16'h3141, 16'h3242, 16'h3343, 16'h3444, 16'h3545, 16'h3646};
    check_stream("dropout");
    chk("dropout_err", 32'(skew_err), 0);

    // Skew 4: overflow at edge k+4, then lane 1 alone errors again.
    pairs.delete();
    cyc(1, 8'h11, 0, 8'h00);
    cyc(1, 8'h12, 0, 8'h00);
    cyc(1, 8'h13, 0, 8'h00);
    cyc(1, 8'h14, 0, 8'h00);
    chk("s4_err_pre", 32'(skew_err), 0);
    cyc(1, 8'h15, 1, 8'hA1);
    chk("s4_err", 32'(skew_err), 1);
    chk("s4_aln", 32'(aligned), 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 8'hA2 + 8'(i));
    chk("s4_aln_lone", 32'(aligned), 0);
    idle(1);
    exp_q.delete();
    check_stream("skew4");

    // Recovery: flushed FIFOs give clean pairs, error stays sticky.
    pairs.delete();
    cyc(1, 8'h55, 1, 8'hC5);
    cyc(1, 8'h56, 1, 8'hC6);
    idle(2);
    exp_q = '{16'h55C5, 16'h56C6};
    check_stream("recov");
    chk("recov_err", 32'(skew_err), 1);

    // Reset mid-burst with lane 0 holding two bytes and a pair on the output.
    pairs.delete();
    cyc(1, 8'h61, 0, 8'h00);
    cyc(1, 8'h62, 1, 8'hD1);
    cyc(1, 8'h63, 1, 8'hD2);
    chk("mb_vld", 32'({valid_out, data_out0, data_out1}), 32'h161D1);
    reset_L = 1'b0;
    #1;
    chk("mb_rst_out", 32'({valid_out, aligned, skew_err, data_out0, data_out1}), 0);
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    @(negedge clock4); reset_L = 1'b1;
    @(posedge clock4); #1;
    pairs.delete();
    cyc(1, 8'h21, 1, 8'hB1);
    idle(3);
    exp_q = '{16'h21B1};
    check_stream("post_rst");
    chk("post_rst_err", 32'(skew_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
